// File: rtl/dmc_pkg.sv
// Shared types and constants for the data-memory controller.
package dmc_pkg;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IO_W   = 6;
   localparam int unsigned WAIT_W = 8;

   localparam logic [ADDR_W-1:0] DMC_RAMEND    = 16'h085F;
   localparam logic [ADDR_W-1:0] DMC_SRAM_BASE = 16'h0060;

   typedef enum logic [2:0] {
      OP_LD   = 3'd0,
      OP_ST   = 3'd1,
      OP_IN   = 3'd2,
      OP_OUT  = 3'd3,
      OP_PUSH = 3'd4,
      OP_POP  = 3'd5
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_CAPTURE,
      ST_DONE
   } state_e;

   function automatic logic is_write(input op_e op);
      return (op == OP_ST) || (op == OP_OUT) || (op == OP_PUSH);
   endfunction
endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register: load has priority, then increment, then decrement (modulo 2^16).
module stack_pointer
   import dmc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RAMEND = DMC_RAMEND
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_value,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W-1:0] sp
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      sp <= RAMEND;
      else if (load)  sp <= load_value;
      else if (inc)   sp <= sp + ADDR_W'(1);
      else if (dec)   sp <= sp - ADDR_W'(1);
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access sequencer: LD/ST/IN/OUT/PUSH/POP onto a registered-read memory map,
// with extra wait states for SRAM-range reads.
module data_mem_ctrl
   import dmc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RAMEND        = DMC_RAMEND,
   parameter logic [ADDR_W-1:0] SRAM_BASE     = DMC_SRAM_BASE,
   parameter int unsigned       SRAM_RD_EXTRA = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              sp_we,
   input  logic [ADDR_W-1:0] sp_wdata,
   output logic [ADDR_W-1:0] sp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_io_only,
   input  logic [DATA_W-1:0] mem_q
);
   state_e            state, next_state;
   op_e               op_q;
   logic              illegal_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              accept, op_legal, sram_read, sp_inc, sp_dec;

   assign req_ready = (state == ST_IDLE) && !sp_we;
   assign accept    = req_valid && req_ready;
   assign op_legal  = (req_op <= 3'd5);
   assign sram_read = !mem_we && !mem_io_only && (mem_addr >= SRAM_BASE) && (SRAM_RD_EXTRA != 0);

   stack_pointer #(.RAMEND(RAMEND)) u_sp (
      .clk        (clk),
      .reset      (reset),
      .load       (sp_we && (state == ST_IDLE)),
      .load_value (sp_wdata),
      .inc        (sp_inc),
      .dec        (sp_dec),
      .sp         (sp)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      sp_inc     = 1'b0;
      sp_dec     = 1'b0;
      case (state)
         ST_IDLE:    if (accept) next_state = op_legal ? ST_ACCESS : ST_DONE;
         ST_ACCESS:  next_state = sram_read ? ST_WAIT : ST_CAPTURE;
         ST_WAIT:    if (wait_cnt == WAIT_W'(SRAM_RD_EXTRA - 1)) next_state = ST_CAPTURE;
         ST_CAPTURE: begin
            next_state = ST_DONE;
            sp_dec     = (op_q == OP_PUSH);
            sp_inc     = (op_q == OP_POP);
         end
         ST_DONE:    next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Memory-side request is captured at acceptance and held until CAPTURE exits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q        <= OP_LD;
         illegal_q   <= 1'b0;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_data_in <= '0;
         mem_io_only <= 1'b0;
      end else if (state == ST_IDLE && accept) begin
         illegal_q <= !op_legal;
         if (op_legal) begin
            op_q        <= op_e'(req_op);
            mem_we      <= is_write(op_e'(req_op));
            mem_data_in <= is_write(op_e'(req_op)) ? req_wdata : '0;
            case (op_e'(req_op))
               OP_IN, OP_OUT: begin
                  mem_addr    <= {{(ADDR_W-IO_W){1'b0}}, req_addr[IO_W-1:0]};
                  mem_io_only <= 1'b1;
               end
               OP_PUSH: mem_addr <= sp;
               OP_POP:  mem_addr <= sp + ADDR_W'(1);
               default: mem_addr <= req_addr;
            endcase
         end
      end else if (state == ST_CAPTURE) begin
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_data_in <= '0;
         mem_io_only <= 1'b0;
      end else if (state == ST_DONE) begin
         illegal_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  wait_cnt <= '0;
      else if (state == ST_WAIT)  wait_cnt <= wait_cnt + WAIT_W'(1);
      else                        wait_cnt <= '0;
   end

   // Response pulse: at CAPTURE exit for real accesses, at DONE exit for illegal ops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (state == ST_CAPTURE) begin
         rsp_valid <= 1'b1;
         rsp_data  <= mem_we ? '0 : mem_q;
         rsp_err   <= 1'b0;
      end else if (state == ST_DONE && illegal_q) begin
         rsp_valid <= 1'b1;
         rsp_data  <= '0;
         rsp_err   <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a registered-read data/IO memory model.
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        sp_we;
   logic [15:0] sp_wdata;
   logic [15:0] sp;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_data_in;
   logic        mem_io_only;
   logic [7:0]  mem_q;

   logic [7:0]  dmem  [0:65535];
   logic [7:0]  iomem [0:63];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   data_mem_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .sp_we       (sp_we),
      .sp_wdata    (sp_wdata),
      .sp          (sp),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_data_in (mem_data_in),
      .mem_io_only (mem_io_only),
      .mem_q       (mem_q)
   );

   // Memory map: separate IO space, registered read data.
   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_io_only) iomem[mem_addr[5:0]] <= mem_data_in;
         else             dmem[mem_addr]       <= mem_data_in;
      end
      mem_q <= mem_io_only ? iomem[mem_addr[5:0]] : dmem[mem_addr];
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check("ready_timeout", 16'(req_ready), 16'd1);
   endtask

   // Issue one request; returns edges from acceptance (acceptance edge = 1) to rsp_valid.
   task automatic do_req(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                         output int edges, output logic [7:0] rd, output logic err,
                         output int io_cyc, output int we_cyc);
      wait_ready();
      io_cyc = 0;
      we_cyc = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      edges = 1;
      while (!rsp_valid && edges < 20) begin
         io_cyc += int'(mem_io_only);
         we_cyc += int'(mem_we);
         @(posedge clk); #1;
         edges++;
      end
      rd  = rsp_data;
      err = rsp_err;
   endtask

   initial begin
      int          e, ioc, wec, seen;
      logic [7:0]  rd;
      logic        er;

      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          e, ioc, wec, seen;
      logic [7:0]  rd;
      logic        er;

      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      sp_we = 1'b0; sp_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_io_only", 16'(mem_io_only), 16'd0);
      reset = 1'b0;
      #1;
      check("rst_ready", 16'(req_ready), 16'd1);
      check("rst_sp", sp, 16'h085F);
      check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
      check("rst_mem_we", 16'(mem_we), 16'd0);
      check("rst_mem_addr", mem_addr, 16'h0000);

      // Low-range data store/load
      do_req(3'd1, 16'h0005, 8'hA5, e, rd, er, ioc, wec);
      check("st5_edges", 16'(e), 16'd3);
      check("st5_data", 16'(rd), 16'h00);
      check("st5_we_cycles", 16'(wec), 16'd2);
      do_req(3'd0, 16'h0005, 8'h00, e, rd, er, ioc, wec);
      check("ld5_edges", 16'(e), 16'd3);
      check("ld5_data", 16'(rd), 16'hA5);
      check("ld5_we_cycles", 16'(wec), 16'd0);

      // IO space; upper address bits must be ignored
      do_req(3'd3, 16'hFF3D, 8'h5A, e, rd, er, ioc, wec);
      check("out_edges", 16'(e), 16'd3);
      check("out_io_cycles", 16'(ioc), 16'd2);
      do_req(3'd2, 16'h003D, 8'h00, e, rd, er, ioc, wec);
      check("in_edges", 16'(e), 16'd3);
      check("in_io_cycles", 16'(ioc), 16'd2);
      check("in_data", 16'(rd), 16'h5A);

      // SRAM range: reads take two extra cycles
      do_req(3'd1, 16'h0100, 8'h3C, e, rd, er, ioc, wec);
      check("st100_edges", 16'(e), 16'd3);
      do_req(3'd0, 16'h0100, 8'h00, e, rd, er, ioc, wec);
      check("ld100_edges", 16'(e), 16'd5);
      check("ld100_data", 16'(rd), 16'h3C);
      check("ld100_io_cycles", 16'(ioc), 16'd0);

      // Stack after reset
      wait_ready();
      reset = 1'b1; #2; reset = 1'b0; #1;
      check("sp_after_rst", sp, 16'h085F);
      do_req(3'd4, 16'h0000, 8'h11, e, rd, er, ioc, wec);
      check("push1_sp", sp, 16'h085E);
      do_req(3'd4, 16'h0000, 8'h22, e, rd, er, ioc, wec);
      check("push2_sp", sp, 16'h085D);
      do_req(3'd5, 16'h0000, 8'h00, e, rd, er, ioc, wec);
      check("pop1_sp", sp, 16'h085E);
      check("pop1_data", 16'(rd), 16'h22);
      check("pop1_edges", 16'(e), 16'd5);
      do_req(3'd5, 16'h0000, 8'h00, e, rd, er, ioc, wec);
      check("pop2_sp", sp, 16'h085F);
      check("pop2_data", 16'(rd), 16'h11);

      // SP load and wrap-around
      wait_ready();
      sp_we = 1'b1; sp_wdata = 16'h0000;
      #1;
      check("ready_during_sp_we", 16'(req_ready), 16'd0);
      @(posedge clk); #1;
      sp_we = 1'b0;
      check("sp_loaded", sp, 16'h0000);
      do_req(3'd4, 16'h0000, 8'h77, e, rd, er, ioc, wec);
      check("push_wrap_sp", sp, 16'hFFFF);
      check("push_wrap_err", 16'(er), 16'd0);
      do_req(3'd5, 16'h0000, 8'h00, e, rd, er, ioc, wec);
      check("pop_wrap_sp", sp, 16'h0000);
      check("pop_wrap_data", 16'(rd), 16'h77);
      check("pop_wrap_edges", 16'(e), 16'd3);

      // Illegal op
      do_req(3'd7, 16'h0200, 8'hEE, e, rd, er, ioc, wec);
      check("ill_edges", 16'(e), 16'd2);
      check("ill_err", 16'(er), 16'd1);
      check("ill_data", 16'(rd), 16'h00);
      check("ill_we_cycles", 16'(wec), 16'd0);

      // Reset in the middle of an SRAM read; sp_we outside IDLE ignored
      wait_ready();
      req_valid = 1'b1; req_op = 3'd0; req_addr = 16'h0100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      sp_we = 1'b1; sp_wdata = 16'h1234;
      @(posedge clk); #1;
      sp_we = 1'b0;
      check("sp_we_busy_ignored", sp, 16'h0000);
      check("midread_addr", mem_addr, 16'h0100);
      reset = 1'b1;
      #1;
      check("midread_rst_addr", mem_addr, 16'h0000);
      check("midread_rst_we", 16'(mem_we), 16'd0);
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         seen += int'(rsp_valid);
      end
      reset = 1'b0;
      repeat (6) begin
         #1;
         seen += int'(rsp_valid);
         @(posedge clk); #1;
      end
      check("midread_no_rsp", 16'(seen), 16'd0);
      check("midread_sp", sp, 16'h085F);
      check("midread_ready", 16'(req_ready), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
